// File: rtl/tank_move_controller.sv
// rtl/tank_move_controller.sv - per-frame tank position/direction generator
// Steps the tank on key requests once every FRAMES_PER_STEP frames and reverts to the last legal spot on collision.
module tank_move_controller #(
    parameter logic [10:0] INIT_X          = 11'd300,
    parameter logic [10:0] INIT_Y          = 11'd400,
    parameter logic [1:0]  INIT_DIR        = 2'b00,
    parameter logic [10:0] SPEED           = 11'd2,
    parameter logic [3:0]  FRAMES_PER_STEP = 4'd1,
    parameter logic [10:0] MIN_X           = 11'd0,
    parameter logic [10:0] MAX_X           = 11'd614,
    parameter logic [10:0] MIN_Y           = 11'd0,
    parameter logic [10:0] MAX_Y           = 11'd454
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [3:0]  moveReq,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  tankDir,
    output logic        moved,
    output logic        blocked
);

    typedef enum logic [1:0] {S_WAIT, S_DECIDE, S_REVERT, S_MOVE} state_t;

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [10:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [1:0]  dir_q, dir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  req_q, req_d;
    logic        hit_q, hit_d;
    logic        moved_q, moved_d;
    logic        blocked_q, blocked_d;

    logic        last_frame;
    logic [1:0]  new_dir;
    logic [10:0] up_y, down_y, left_x, right_x;

    assign last_frame = (cnt_q == FRAMES_PER_STEP - 4'd1);

    // 12-bit compares keep the clamps free of wrap-around at both ends
    assign up_y    = ({1'b0, y_q} < ({1'b0, MIN_Y} + {1'b0, SPEED})) ? MIN_Y : (y_q - SPEED);
    assign down_y  = (({1'b0, y_q} + {1'b0, SPEED}) > {1'b0, MAX_Y}) ? MAX_Y : (y_q + SPEED);
    assign left_x  = ({1'b0, x_q} < ({1'b0, MIN_X} + {1'b0, SPEED})) ? MIN_X : (x_q - SPEED);
    assign right_x = (({1'b0, x_q} + {1'b0, SPEED}) > {1'b0, MAX_X}) ? MAX_X : (x_q + SPEED);

    always_comb begin
        new_dir = 2'b11;
        if (req_q[3])      new_dir = 2'b00;
        else if (req_q[2]) new_dir = 2'b01;
        else if (req_q[1]) new_dir = 2'b10;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        prev_x_d  = prev_x_q;
        prev_y_d  = prev_y_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        hit_d     = hit_q | collision;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (startOfFrame) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                cnt_d = last_frame ? 4'd0 : cnt_q + 4'd1;
                req_d = moveReq;
                if (hit_q) begin
                    state_d   = S_REVERT;
                    blocked_d = 1'b1;
                end else if (moveReq != 4'd0 && last_frame) begin
                    state_d = S_MOVE;
                    moved_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_REVERT: begin
                x_d     = prev_x_q;
                y_d     = prev_y_q;
                hit_d   = collision;
                state_d = S_WAIT;
            end
            S_MOVE: begin
                prev_x_d = x_q;
                prev_y_d = y_q;
                dir_d    = new_dir;
                case (new_dir)
                    2'b00:   y_d = up_y;
                    2'b01:   x_d = right_x;
                    2'b10:   y_d = down_y;
                    default: x_d = left_x;
                endcase
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_WAIT;
            x_q       <= INIT_X;
            y_q       <= INIT_Y;
            prev_x_q  <= INIT_X;
            prev_y_q  <= INIT_Y;
            dir_q     <= INIT_DIR;
            cnt_q     <= 4'd0;
            req_q     <= 4'd0;
            hit_q     <= 1'b0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            prev_x_q  <= prev_x_d;
            prev_y_q  <= prev_y_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            hit_q     <= hit_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign topLeftX = x_q;
    assign topLeftY = y_q;
    assign tankDir  = dir_q;
    assign moved    = moved_q;
    assign blocked  = blocked_q;

endmodule
